// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared constants for the iterative RV32M divider.
//   - funct3 codes for DIV/DIVU/REM/REMU
//   - divider FSM state encoding (2 bits)
//   - default operand width
//   - small op-decoding helpers used at request acceptance
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    typedef enum logic [1:0] {
        DIV_STATE_IDLE = 2'b00,
        DIV_STATE_CALC = 2'b01,
        DIV_STATE_DONE = 2'b10
    } div_state_e;

    // True for the signed variants (DIV, REM).
    function automatic logic f_is_signed(input logic [2:0] op);
        return (op == INST_DIV) || (op == INST_REM);
    endfunction

    // True when the remainder rather than the quotient is returned.
    function automatic logic f_is_rem(input logic [2:0] op);
        return (op == INST_REM) || (op == INST_REMU);
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between execute (master) and the
// divider (slave).
//   master drives: start_i, op_i, dividend_i, divisor_i, rd_i, flush_i
//   slave drives : div_busy_o, ready_o, result_o, rd_o
interface div_unit_if #(
    parameter int DATA_W = 32
);
    logic              start_i;
    logic [2:0]        op_i;
    logic [DATA_W-1:0] dividend_i;
    logic [DATA_W-1:0] divisor_i;
    logic [4:0]        rd_i;
    logic              flush_i;
    logic              div_busy_o;
    logic              ready_o;
    logic [DATA_W-1:0] result_o;
    logic [4:0]        rd_o;

    modport master (
        output start_i, op_i, dividend_i, divisor_i, rd_i, flush_i,
        input  div_busy_o, ready_o, result_o, rd_o
    );

    modport slave (
        input  start_i, op_i, dividend_i, divisor_i, rd_i, flush_i,
        output div_busy_o, ready_o, result_o, rd_o
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider, one quotient bit per cycle.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - div_unit_if.slave: request (start/op/operands/rd/flush) in,
//          busy / ready pulse / result / rd out
// Operands are converted to magnitudes on acceptance; the signs needed to
// fix up quotient and remainder are applied while entering DONE so the
// result leaves the block straight from a register.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic        clk,
    input  logic        rst,
    div_unit_if.slave   bus
);

    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] ZERO     = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};

    div_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rem;      // partial remainder
    logic [DATA_W-1:0] r_quo;      // dividend bits shift out the top, quotient bits in at the bottom
    logic [DATA_W-1:0] r_dvs;      // divisor magnitude
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_is_rem;
    logic [4:0]        r_rd;
    logic              r_busy;
    logic              r_ready;
    logic [DATA_W-1:0] r_result;
    logic [4:0]        r_rd_o;

    logic              w_signed;
    logic              w_dvd_neg;
    logic              w_dvs_neg;
    logic [DATA_W-1:0] w_dvd_mag;
    logic [DATA_W-1:0] w_dvs_mag;
    logic              w_div_zero;
    logic              w_ovf;
    logic [DATA_W:0]   w_shift;
    logic [DATA_W:0]   w_diff;
    logic              w_qbit;
    logic [DATA_W-1:0] w_rem_nxt;
    logic [DATA_W-1:0] w_quo_nxt;
    logic [DATA_W-1:0] w_res_fin;

    // Request decode: operand magnitudes and special-case detection.
    always_comb begin
        w_signed   = f_is_signed(bus.op_i);
        w_dvd_neg  = w_signed & bus.dividend_i[DATA_W-1];
        w_dvs_neg  = w_signed & bus.divisor_i[DATA_W-1];
        w_dvd_mag  = w_dvd_neg ? (ZERO - bus.dividend_i) : bus.dividend_i;
        w_dvs_mag  = w_dvs_neg ? (ZERO - bus.divisor_i) : bus.divisor_i;
        w_div_zero = (bus.divisor_i == ZERO);
        w_ovf      = w_signed && (bus.dividend_i == MIN_NEG) && (bus.divisor_i == ALL_ONES);
    end

    // One shift-subtract step through the single shared subtractor.
    always_comb begin
        w_shift = {r_rem, r_quo[DATA_W-1]};
        w_diff  = w_shift - {1'b0, r_dvs};
        // Since the remainder is always below the divisor, a negative trial
        // result means the shifted value itself still fits in DATA_W bits.
        if (!w_diff[DATA_W]) begin
            w_qbit    = 1'b1;
            w_rem_nxt = w_diff[DATA_W-1:0];
        end else begin
            w_qbit    = 1'b0;
            w_rem_nxt = w_shift[DATA_W-1:0];
        end
        w_quo_nxt = {r_quo[DATA_W-2:0], w_qbit};
    end

    // Sign correction of the final step's outputs, selected by operation.
    always_comb begin
        if (r_is_rem) begin
            w_res_fin = r_neg_r ? (ZERO - w_rem_nxt) : w_rem_nxt;
        end else begin
            w_res_fin = r_neg_q ? (ZERO - w_quo_nxt) : w_quo_nxt;
        end
    end

    // Divider FSM with datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= DIV_STATE_IDLE;
            r_cnt    <= {CNT_W{1'b0}};
            r_rem    <= ZERO;
            r_quo    <= ZERO;
            r_dvs    <= ZERO;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_rem <= 1'b0;
            r_rd     <= 5'd0;
            r_busy   <= 1'b0;
            r_ready  <= 1'b0;
            r_result <= ZERO;
            r_rd_o   <= 5'd0;
        end else if (bus.flush_i) begin
            // Abort: no ready pulse, last result/rd are left untouched.
            r_state <= DIV_STATE_IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                DIV_STATE_IDLE: begin
                    r_ready <= 1'b0;
                    if (bus.start_i) begin
                        r_is_rem <= f_is_rem(bus.op_i);
                        r_rd     <= bus.rd_i;
                        r_neg_q  <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r  <= w_dvd_neg;
                        r_busy   <= 1'b1;
                        if (w_div_zero || w_ovf) begin
                            r_state <= DIV_STATE_DONE;
                            r_ready <= 1'b1;
                            r_rd_o  <= bus.rd_i;
                            if (w_div_zero) begin
                                r_result <= f_is_rem(bus.op_i) ? bus.dividend_i : ALL_ONES;
                            end else begin
                                r_result <= f_is_rem(bus.op_i) ? ZERO : MIN_NEG;
                            end
                        end else begin
                            r_state <= DIV_STATE_CALC;
                            r_cnt   <= {CNT_W{1'b0}};
                            r_rem   <= ZERO;
                            r_quo   <= w_dvd_mag;
                            r_dvs   <= w_dvs_mag;
                        end
                    end
                end
                DIV_STATE_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + CNT_ONE;
                    if (r_cnt == LAST_CNT) begin
                        r_state  <= DIV_STATE_DONE;
                        r_ready  <= 1'b1;
                        r_result <= w_res_fin;
                        r_rd_o   <= r_rd;
                    end
                end
                DIV_STATE_DONE: begin
                    r_state <= DIV_STATE_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                end
                default: begin
                    r_state <= DIV_STATE_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.div_busy_o = r_busy;
    assign bus.ready_o    = r_ready;
    assign bus.result_o   = r_result;
    assign bus.rd_o       = r_rd_o;

endmodule
